// File: rtl/i2c_mpu_pkg.sv
// Shared types and register map for the MPU6050 I2C target emulator.
package i2c_mpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] ACCEL_XOUT_L = 8'h3C;
  localparam logic [7:0] ACCEL_YOUT_H = 8'h3D;
  localparam logic [7:0] ACCEL_YOUT_L = 8'h3E;
  localparam logic [7:0] ACCEL_ZOUT_H = 8'h3F;
  localparam logic [7:0] ACCEL_ZOUT_L = 8'h40;
  localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] WHO_AM_I     = 8'h75;

  localparam logic [7:0] PWR_MGMT_RST = 8'h40;

  // snap packs {x, y, z}, each 16 bits, high byte first
  function automatic logic [7:0] reg_read(input logic [7:0]  addr,
                                          input logic [47:0] snap,
                                          input logic [7:0]  pwr,
                                          input logic [7:0]  who);
    case (addr)
      ACCEL_XOUT_H: reg_read = snap[47:40];
      ACCEL_XOUT_L: reg_read = snap[39:32];
      ACCEL_YOUT_H: reg_read = snap[31:24];
      ACCEL_YOUT_L: reg_read = snap[23:16];
      ACCEL_ZOUT_H: reg_read = snap[15:8];
      ACCEL_ZOUT_L: reg_read = snap[7:0];
      PWR_MGMT_1:   reg_read = pwr;
      WHO_AM_I:     reg_read = who;
      default:      reg_read = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/i2c_mpu_responder_line_cond.sv
// SCL/SDA synchronizer + glitch filter, producing bus edge and START/STOP pulses.
module i2c_line_cond #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [1:0]          r_scl_s, r_sda_s;
  logic [FILT_LEN-2:0] r_scl_h, r_sda_h;
  logic                r_scl_f, r_scl_q, r_sda_f, r_sda_q;
  logic [FILT_LEN-1:0] w_scl_win, w_sda_win;

  // window = newest synchronized sample plus FILT_LEN-1 older ones
  assign w_scl_win = {r_scl_h, r_scl_s[1]};
  assign w_sda_win = {r_sda_h, r_sda_s[1]};

  // idle bus is high, so reset to 1 to avoid spurious edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_s <= '1;
      r_sda_s <= '1;
      r_scl_h <= '1;
      r_sda_h <= '1;
      r_scl_f <= 1'b1;
      r_scl_q <= 1'b1;
      r_sda_f <= 1'b1;
      r_sda_q <= 1'b1;
    end else begin
      r_scl_s <= {r_scl_s[0], i_scl};
      r_sda_s <= {r_sda_s[0], i_sda};
      r_scl_h <= w_scl_win[FILT_LEN-2:0];
      r_sda_h <= w_sda_win[FILT_LEN-2:0];
      if (w_scl_win == '1)      r_scl_f <= 1'b1;
      else if (w_scl_win == '0) r_scl_f <= 1'b0;
      if (w_sda_win == '1)      r_sda_f <= 1'b1;
      else if (w_sda_win == '0) r_sda_f <= 1'b0;
      r_scl_q <= r_scl_f;
      r_sda_q <= r_sda_f;
    end
  end

  assign o_scl_rise = r_scl_f & ~r_scl_q;
  assign o_scl_fall = ~r_scl_f & r_scl_q;
  assign o_start    = r_scl_f & r_scl_q & ~r_sda_f & r_sda_q;
  assign o_stop     = r_scl_f & r_scl_q & r_sda_f & ~r_sda_q;
  assign o_sda      = r_sda_f;

endmodule

// File: rtl/i2c_mpu_responder.sv
// I2C target emulating the MPU6050 register interface (accel, PWR_MGMT_1, WHO_AM_I).
//   state        | meaning
//   ST_IDLE      | waiting for START
//   ST_ADDR      | shifting in device address + R/W
//   ST_ADDR_ACK  | driving ACK for a matched address
//   ST_REG       | shifting in register pointer
//   ST_REG_ACK   | driving ACK for the pointer byte
//   ST_WDATA     | shifting in a write data byte
//   ST_WDATA_ACK | driving ACK, then committing the write
//   ST_RDATA     | shifting out the byte at the pointer
//   ST_RACK      | sampling the master's ACK/NACK
//   ST_IGNORE    | not addressed / NACKed; wait for START or STOP
module i2c_mpu_responder
  import i2c_mpu_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter int         FILT_LEN     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  output logic [7:0]  pwr_mgmt,
  output logic        busy,
  output logic        wr_stb,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_line_cond (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (scl_i),
    .i_sda      (sda_i),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  state_t      r_state;
  logic [7:0]  r_shift, r_ptr, r_pwr, r_wr_addr, r_wr_data;
  logic [3:0]  r_bitcnt;
  logic        r_ack_on, r_rw, r_sda_oe, r_busy, r_wr_stb;
  logic [47:0] r_snap;

  logic [7:0]  w_byte, w_rd_first, w_rd_next;
  logic [47:0] w_live;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_live     = {accel_x, accel_y, accel_z};
  // first byte of a read is served from the live inputs, which equal the snapshot being taken
  assign w_rd_first = reg_read(r_ptr, w_live, r_pwr, WHO_AM_I_VAL);
  assign w_rd_next  = reg_read(r_ptr, r_snap, r_pwr, WHO_AM_I_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_pwr     <= PWR_MGMT_RST;
      r_bitcnt  <= '0;
      r_ack_on  <= 1'b0;
      r_rw      <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_snap    <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_ack_on <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
        r_ack_on <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              if (w_byte[7:1] == DEV_ADDR) begin
                r_state <= ST_ADDR_ACK;
                r_busy  <= 1'b1;
                r_rw    <= w_sda;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_REG: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) begin
              r_ptr   <= w_byte;
              r_state <= ST_REG_ACK;
            end
          end
          ST_WDATA: if (w_scl_rise) begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd7) r_state <= ST_WDATA_ACK;
          end
          // first fall after the 8th bit asserts ACK, the second ends the ACK slot
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: if (w_scl_fall) begin
            if (!r_ack_on) begin
              r_sda_oe <= 1'b1;
              r_ack_on <= 1'b1;
            end else begin
              r_ack_on <= 1'b0;
              r_sda_oe <= 1'b0;
              r_bitcnt <= '0;
              if (r_state == ST_ADDR_ACK) begin
                if (r_rw) begin
                  r_snap   <= w_live;
                  r_shift  <= w_rd_first;
                  r_sda_oe <= ~w_rd_first[7];
                  r_state  <= ST_RDATA;
                end else begin
                  r_state <= ST_REG;
                end
              end else if (r_state == ST_REG_ACK) begin
                r_state <= ST_WDATA;
              end else begin
                r_wr_stb  <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= r_shift;
                if (r_ptr == PWR_MGMT_1) r_pwr <= r_shift;
                r_ptr   <= r_ptr + 8'd1;
                r_state <= ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            if (w_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_RACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          ST_RACK: begin
            if (w_scl_rise) begin
              if (!w_sda) begin
                r_ptr    <= r_ptr + 8'd1;
                r_ack_on <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end else if (w_scl_fall && r_ack_on) begin
              r_ack_on <= 1'b0;
              r_shift  <= w_rd_next;
              r_sda_oe <= ~w_rd_next[7];
              r_bitcnt <= '0;
              r_state  <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign busy     = r_busy;
  assign wr_stb   = r_wr_stb;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign pwr_mgmt = r_pwr;

endmodule
